// File: rtl/nitc_pkg.sv
// Shared definitions for the NITC-RISC24 multicycle controller: state and opcode
// encodings, datapath mux-select encodings and the packed control word.
package nitc_pkg;

   localparam int ST_W = 5;

   typedef enum logic [4:0] {
      S_FETCH    = 5'd0,
      S_DECODE   = 5'd1,
      S_MEMADR   = 5'd2,
      S_MEMRD    = 5'd3,
      S_MEMWB    = 5'd4,
      S_MEMWR    = 5'd5,
      S_EXECUTE  = 5'd6,
      S_ALUWB    = 5'd7,
      S_BRANCH   = 5'd8,
      S_JALRW    = 5'd9,
      S_JALPC    = 5'd10
   } state_t;

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_ADI = 4'b0001;
   localparam logic [3:0] OP_NDU = 4'b0010;
   localparam logic [3:0] OP_LW  = 4'b0100;
   localparam logic [3:0] OP_SW  = 4'b0101;
   localparam logic [3:0] OP_BEQ = 4'b1100;
   localparam logic [3:0] OP_JAL = 4'b1000;
   localparam logic [3:0] OP_JLR = 4'b1001;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_REGA   = 2'b10;

   localparam logic [1:0] REGDST_RT   = 2'b00;
   localparam logic [1:0] REGDST_RD   = 2'b01;
   localparam logic [1:0] REGDST_LINK = 2'b10;

   localparam logic [1:0] WB_ALUOUT = 2'b00;
   localparam logic [1:0] WB_MEM    = 2'b01;
   localparam logic [1:0] WB_PC     = 2'b10;

   localparam logic [1:0] ALUB_REGB = 2'b00;
   localparam logic [1:0] ALUB_ONE  = 2'b01;
   localparam logic [1:0] ALUB_IMM6 = 2'b10;
   localparam logic [1:0] ALUB_IMM9 = 2'b11;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;
   localparam logic [1:0] ALUOP_NAND  = 2'b11;

   typedef struct packed {
      logic       pcwrite;
      logic       branch;
      logic [1:0] pcsrc;
      logic       iord;
      logic       memwrite;
      logic       irwrite;
      logic       regwrite;
      logic [1:0] regdst;
      logic [1:0] wbsrc;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] aluop;
      logic       instr_done;
   } ctrl_t;

endpackage

// File: rtl/nitc_ctrl_outdec.sv
// Combinational state/opcode -> control-word decoder. Moore outputs per state,
// plus the few strobes qualified by mem_ready; all strobes held low in reset.
module nitc_ctrl_outdec
   import nitc_pkg::*;
(
   input  state_t     i_state,
   input  logic [3:0] i_opcode,
   input  logic       i_mem_ready,
   input  logic       i_rst_n,
   output ctrl_t      o_ctrl
);

   ctrl_t w_ctrl;
   logic  w_legal;

   always_comb begin
      w_legal = (i_opcode == OP_ADD) || (i_opcode == OP_ADI) || (i_opcode == OP_NDU) ||
                (i_opcode == OP_LW)  || (i_opcode == OP_SW)  || (i_opcode == OP_BEQ) ||
                (i_opcode == OP_JAL) || (i_opcode == OP_JLR);
   end

   always_comb begin
      w_ctrl = '0;
      case (i_state)
         S_FETCH: begin
            w_ctrl.alusrcb = ALUB_ONE;
            w_ctrl.aluop   = ALUOP_ADD;
            w_ctrl.irwrite = i_mem_ready;
            w_ctrl.pcwrite = i_mem_ready;
         end
         S_DECODE: begin
            // Branch target is precomputed into ALUOut here.
            w_ctrl.alusrcb    = ALUB_IMM9;
            w_ctrl.instr_done = !w_legal;
         end
         S_MEMADR: begin
            w_ctrl.alusrca = 1'b1;
            w_ctrl.alusrcb = ALUB_IMM6;
         end
         S_MEMRD: w_ctrl.iord = 1'b1;
         S_MEMWB: begin
            w_ctrl.regwrite   = 1'b1;
            w_ctrl.wbsrc      = WB_MEM;
            w_ctrl.regdst     = REGDST_RT;
            w_ctrl.instr_done = 1'b1;
         end
         S_MEMWR: begin
            w_ctrl.iord       = 1'b1;
            w_ctrl.memwrite   = 1'b1;
            w_ctrl.instr_done = i_mem_ready;
         end
         S_EXECUTE: begin
            w_ctrl.alusrca = 1'b1;
            if (i_opcode == OP_ADD) begin
               w_ctrl.alusrcb = ALUB_REGB;
               w_ctrl.aluop   = ALUOP_FUNCT;
            end else if (i_opcode == OP_ADI) begin
               w_ctrl.alusrcb = ALUB_IMM6;
               w_ctrl.aluop   = ALUOP_ADD;
            end else if (i_opcode == OP_NDU) begin
               w_ctrl.alusrcb = ALUB_REGB;
               w_ctrl.aluop   = ALUOP_NAND;
            end
         end
         S_ALUWB: begin
            w_ctrl.regwrite   = 1'b1;
            w_ctrl.wbsrc      = WB_ALUOUT;
            w_ctrl.regdst     = (i_opcode == OP_ADI) ? REGDST_RT : REGDST_RD;
            w_ctrl.instr_done = 1'b1;
         end
         S_BRANCH: begin
            w_ctrl.alusrca    = 1'b1;
            w_ctrl.alusrcb    = ALUB_REGB;
            w_ctrl.aluop      = ALUOP_SUB;
            w_ctrl.branch     = 1'b1;
            w_ctrl.pcsrc      = PCSRC_ALUOUT;
            w_ctrl.instr_done = 1'b1;
         end
         S_JALRW: begin
            w_ctrl.regwrite = 1'b1;
            w_ctrl.regdst   = REGDST_LINK;
            w_ctrl.wbsrc    = WB_PC;
         end
         S_JALPC: begin
            w_ctrl.pcwrite    = 1'b1;
            w_ctrl.pcsrc      = (i_opcode == OP_JLR) ? PCSRC_REGA : PCSRC_ALUOUT;
            w_ctrl.instr_done = 1'b1;
         end
         default: w_ctrl = '0;
      endcase
      if (!i_rst_n) begin
         w_ctrl.pcwrite    = 1'b0;
         w_ctrl.branch     = 1'b0;
         w_ctrl.memwrite   = 1'b0;
         w_ctrl.irwrite    = 1'b0;
         w_ctrl.regwrite   = 1'b0;
         w_ctrl.instr_done = 1'b0;
      end
   end

   assign o_ctrl = w_ctrl;

endmodule

// File: rtl/nitc_control_fsm.sv
// NITC-RISC24 multicycle controller: state register and next-state logic; the
// control word comes from nitc_ctrl_outdec.
module nitc_control_fsm
   import nitc_pkg::*;
#(
   parameter int ST_W = 5
)(
   input  logic            clk,
   input  logic            reset,
   input  logic [3:0]      opcode,
   input  logic            mem_ready,
   output logic [ST_W-1:0] state,
   output logic            pcwrite,
   output logic            branch,
   output logic [1:0]      pcsrc,
   output logic            iord,
   output logic            memwrite,
   output logic            irwrite,
   output logic            regwrite,
   output logic [1:0]      regdst,
   output logic [1:0]      wbsrc,
   output logic            alusrca,
   output logic [1:0]      alusrcb,
   output logic [1:0]      aluop,
   output logic            instr_done
);

   state_t r_state;
   state_t w_next;
   ctrl_t  w_ctrl;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_FETCH;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = S_FETCH;
      case (r_state)
         S_FETCH:   w_next = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW:          w_next = S_MEMADR;
               OP_ADD, OP_ADI, OP_NDU: w_next = S_EXECUTE;
               OP_BEQ:                w_next = S_BRANCH;
               OP_JAL, OP_JLR:        w_next = S_JALRW;
               default:               w_next = S_FETCH;
            endcase
         end
         S_MEMADR:  w_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:   w_next = mem_ready ? S_MEMWB : S_MEMRD;
         S_MEMWB:   w_next = S_FETCH;
         S_MEMWR:   w_next = mem_ready ? S_FETCH : S_MEMWR;
         S_EXECUTE: w_next = S_ALUWB;
         S_ALUWB:   w_next = S_FETCH;
         S_BRANCH:  w_next = S_FETCH;
         S_JALRW:   w_next = S_JALPC;
         S_JALPC:   w_next = S_FETCH;
         default:   w_next = S_FETCH;
      endcase
   end

   nitc_ctrl_outdec u_outdec (
      .i_state     (r_state),
      .i_opcode    (opcode),
      .i_mem_ready (mem_ready),
      .i_rst_n     (reset),
      .o_ctrl      (w_ctrl)
   );

   assign state      = ST_W'(r_state);
   assign pcwrite    = w_ctrl.pcwrite;
   assign branch     = w_ctrl.branch;
   assign pcsrc      = w_ctrl.pcsrc;
   assign iord       = w_ctrl.iord;
   assign memwrite   = w_ctrl.memwrite;
   assign irwrite    = w_ctrl.irwrite;
   assign regwrite   = w_ctrl.regwrite;
   assign regdst     = w_ctrl.regdst;
   assign wbsrc      = w_ctrl.wbsrc;
   assign alusrca    = w_ctrl.alusrca;
   assign alusrcb    = w_ctrl.alusrcb;
   assign aluop      = w_ctrl.aluop;
   assign instr_done = w_ctrl.instr_done;

endmodule
